pc_branch_unit: RTL and testbench

- Datapath-side consumer of the branch control word produced by the control unit.
- Holds the program counter, NZCV status register, instruction register and CPU state register.
- Executes the PC function (hold / +4 / register load / PC-relative jump), resolves conditional branches against registered status, and feeds state and instruction back to the control unit each cycle.

---
 rtl/cpu_ctrl_pkg.sv | 43 ++++
 rtl/branch_cond_eval.sv | 49 ++++
 rtl/pc_branch_unit.sv | 83 ++++++++
 tb/tb_pc_branch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings between the control unit and the datapath branch logic.
//   - PC function select codes (pc_fs)
//   - ARM-style 4-bit condition codes
//   - Bit positions inside the {N,Z,C,V} status word
//   - CPU state encodings fed back to the control unit
package cpu_ctrl_pkg;

  // PC function select
  localparam logic [1:0] PC_HOLD  = 2'b00;
  localparam logic [1:0] PC_PLUS4 = 2'b01;
  localparam logic [1:0] PC_IN    = 2'b10;
  localparam logic [1:0] PC_JUMP  = 2'b11;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_HS = 4'b0010;
  localparam logic [3:0] COND_LO = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Status bit indices within {N,Z,C,V}
  localparam int unsigned STATUS_N = 3;
  localparam int unsigned STATUS_Z = 2;
  localparam int unsigned STATUS_C = 1;
  localparam int unsigned STATUS_V = 0;

  // CPU state encodings
  localparam logic [3:0] FETCH = 4'd0;
  localparam logic [3:0] EX0   = 4'd1;
  localparam logic [3:0] EX1   = 4'd2;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition-code evaluator.
// Ports:
//   cond      - 4-bit ARM condition code
//   status    - registered {N,Z,C,V}
//   cond_true - 1 when the condition holds for the given flags
module branch_cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] status,
  output logic       cond_true
);

  logic flag_n, flag_z, flag_c, flag_v;
  logic hi, ge, gt;

  assign flag_n = status[STATUS_N];
  assign flag_z = status[STATUS_Z];
  assign flag_c = status[STATUS_C];
  assign flag_v = status[STATUS_V];

  assign hi = flag_c & ~flag_z;
  assign ge = (flag_n == flag_v);
  assign gt = ~flag_z & ge;

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      COND_EQ: cond_true = flag_z;
      COND_NE: cond_true = ~flag_z;
      COND_HS: cond_true = flag_c;
      COND_LO: cond_true = ~flag_c;
      COND_MI: cond_true = flag_n;
      COND_PL: cond_true = ~flag_n;
      COND_VS: cond_true = flag_v;
      COND_VC: cond_true = ~flag_v;
      COND_HI: cond_true = hi;
      COND_LS: cond_true = ~hi;
      COND_GE: cond_true = ge;
      COND_LT: cond_true = ~ge;
      COND_GT: cond_true = gt;
      COND_LE: cond_true = ~gt;
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter, status, instruction and state registers plus PC next-value mux.
// Ports:
//   clock, reset       - clock; asynchronous active-high reset
//   pc_fs              - PC function (hold / +4 / load reg_target / PC-relative jump)
//   cond_en, cond      - make the jump conditional on cond evaluated against status
//   offset, reg_target - word offset for jumps, register value for loads
//   status_load/_in    - NZCV register load
//   ns                 - next CPU state from the control unit
//   ir_load, instr_in  - instruction register load
//   pc, status, state, ir - registered outputs
//   link_addr          - pc+4 (BL return address)
//   branch_taken       - jump path selected this cycle
module pc_branch_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned          PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          pc_fs,
  input  logic                cond_en,
  input  logic [3:0]          cond,
  input  logic [PC_WIDTH-1:0] offset,
  input  logic [PC_WIDTH-1:0] reg_target,
  input  logic                status_load,
  input  logic [3:0]          status_in,
  input  logic [3:0]          ns,
  input  logic                ir_load,
  input  logic [31:0]         instr_in,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] link_addr,
  output logic [3:0]          status,
  output logic [3:0]          state,
  output logic [31:0]         ir,
  output logic                branch_taken
);

  localparam logic [PC_WIDTH-1:0] PcStep = PC_WIDTH'(4);

  logic                cond_true;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] pc_next;

  // Evaluated against the registered flags only, so a same-cycle status_load
  // cannot influence this cycle's branch decision.
  branch_cond_eval u_cond_eval (
    .cond      (cond),
    .status    (status),
    .cond_true (cond_true)
  );

  assign link_addr    = pc + PcStep;
  assign branch_taken = (pc_fs == PC_JUMP) && (!cond_en || cond_true);
  // Shift drops offset's top two bits; wrap is modulo 2^PC_WIDTH.
  assign jump_target  = pc + {offset[PC_WIDTH-3:0], 2'b00};

  always_comb begin
    pc_next = pc;
    unique case (pc_fs)
      PC_HOLD:  pc_next = pc;
      PC_PLUS4: pc_next = link_addr;
      PC_IN:    pc_next = {reg_target[PC_WIDTH-1:2], 2'b00};
      PC_JUMP:  pc_next = branch_taken ? jump_target : link_addr;
      default:  pc_next = pc;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      status <= 4'b0000;
      state  <= 4'b0000;
      ir     <= 32'd0;
    end else begin
      pc    <= pc_next;
      state <= ns;
      if (status_load) status <= status_in;
      if (ir_load)     ir     <= instr_in;
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
module tb_pc_branch_unit;
  import cpu_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  pc_fs;
  logic        cond_en;
  logic [3:0]  cond;
  logic [63:0] offset;
  logic [63:0] reg_target;
  logic        status_load;
  logic [3:0]  status_in;
  logic [3:0]  ns;
  logic        ir_load;
  logic [31:0] instr_in;
  logic [63:0] pc;
  logic [63:0] link_addr;
  logic [3:0]  status;
  logic [3:0]  state;
  logic [31:0] ir;
  logic        branch_taken;

  pc_branch_unit #(
    .PC_WIDTH (64),
    .RESET_PC (64'd0)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pc_fs        (pc_fs),
    .cond_en      (cond_en),
    .cond         (cond),
    .offset       (offset),
    .reg_target   (reg_target),
    .status_load  (status_load),
    .status_in    (status_in),
    .ns           (ns),
    .ir_load      (ir_load),
    .instr_in     (instr_in),
    .pc           (pc),
    .link_addr    (link_addr),
    .status       (status),
    .state        (state),
    .ir           (ir),
    .branch_taken (branch_taken)
  );

  always #50 clock = ~clock;

  typedef struct {
    string       tag;
    logic [63:0] pc;
    logic [3:0]  status;
    logic [3:0]  state;
    logic [31:0] ir;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [63:0] m_pc;
  logic [3:0]  m_status;
  logic [3:0]  m_state;
  logic [31:0] m_ir;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ARM condition table: pairs share a base test, odd codes invert (except 1111).
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] s);
    logic n, z, cf, v, r;
    n = s[3]; z = s[2]; cf = s[1]; v = s[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cf;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cf && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[0] && c != 4'b1111) r = !r;
    return r;
  endfunction

  task automatic model_reset();
    m_pc = 64'd0; m_status = 4'd0; m_state = 4'd0; m_ir = 32'd0;
  endtask

  // Drive one cycle of inputs, check combinational outputs, push the expected
  // post-edge register contents, then clock and compare.
  task automatic drive(input string tag, input logic [1:0] fs, input logic cen,
                       input logic [3:0] cnd, input logic [63:0] off, input logic [63:0] tgt,
                       input logic sl, input logic [3:0] sin, input logic [3:0] nsv,
                       input logic il, input logic [31:0] iin);
    exp_t        e;
    logic        tk;
    logic [63:0] nxt;
    pc_fs = fs; cond_en = cen; cond = cnd; offset = off; reg_target = tgt;
    status_load = sl; status_in = sin; ns = nsv; ir_load = il; instr_in = iin;
    #1;
    tk = (fs == 2'b11) && (!cen || ref_cond(cnd, m_status));
    check({tag, ".taken"}, {63'd0, branch_taken}, {63'd0, tk});
    check({tag, ".link"}, link_addr, m_pc + 64'd4);
    case (fs)
      2'b00:   nxt = m_pc;
      2'b01:   nxt = m_pc + 64'd4;
      2'b10:   nxt = tgt & ~64'd3;
      default: nxt = tk ? m_pc + (off * 64'd4) : m_pc + 64'd4;
    endcase
    m_pc = nxt;
    if (sl) m_status = sin;
    m_state = nsv;
    if (il) m_ir = iin;
    e.tag = tag; e.pc = m_pc; e.status = m_status; e.state = m_state; e.ir = m_ir;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check({e.tag, ".pc"}, pc, e.pc);
    check({e.tag, ".status"}, {60'd0, status}, {60'd0, e.status});
    check({e.tag, ".state"}, {60'd0, state}, {60'd0, e.state});
    check({e.tag, ".ir"}, {32'd0, ir}, {32'd0, e.ir});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    pc_fs = 2'b00; cond_en = 1'b0; cond = 4'd0; offset = '0; reg_target = '0;
    status_load = 1'b0; status_in = 4'd0; ns = 4'd0; ir_load = 1'b0; instr_in = '0;
    model_reset();
    #120;
    check("rst.pc", pc, 64'd0);
    check("rst.status", {60'd0, status}, 64'd0);
    check("rst.state", {60'd0, state}, 64'd0);
    check("rst.ir", {32'd0, ir}, 64'd0);
    reset = 1'b0;
    #10;

    // Sequential +4, state lags ns by one edge
    drive("inc1", PC_PLUS4, 1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 4'd0, EX0, 1'b1, 32'hDEAD_BEEF);
    drive("inc2", PC_PLUS4, 1'b0, 4'd0, 64'd0, 64'd0, 1'b1, 4'b1010, EX1, 1'b0, 32'h0);
    drive("inc3", PC_PLUS4, 1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 4'd0, FETCH, 1'b1, 32'h1234_5678);
    check("inc3.pc_const", pc, 64'hC);

    // Asynchronous reset mid-cycle
    #20;
    reset = 1'b1;
    #1;
    check("arst.pc", pc, 64'd0);
    check("arst.status", {60'd0, status}, 64'd0);
    check("arst.state", {60'd0, state}, 64'd0);
    check("arst.ir", {32'd0, ir}, 64'd0);
    #10;
    reset = 1'b0;
    model_reset();

    // CBZ taken
    drive("setpc", PC_IN, 1'b0, 4'd0, 64'd0, 64'h100, 1'b0, 4'd0, FETCH, 1'b0, 32'h0);
    drive("cbz_ex0", PC_HOLD, 1'b0, 4'd0, 64'd0, 64'd0, 1'b1, 4'b0100, EX0, 1'b0, 32'h0);
    drive("cbz_ex1", PC_JUMP, 1'b1, COND_EQ, 64'd3, 64'd0, 1'b0, 4'd0, EX1, 1'b0, 32'h0);
    check("cbz.pc_const", pc, 64'h10C);

    // CBZ not taken
    drive("setpc2", PC_IN, 1'b0, 4'd0, 64'd0, 64'h100, 1'b0, 4'd0, FETCH, 1'b0, 32'h0);
    drive("cbzn_ex0", PC_HOLD, 1'b0, 4'd0, 64'd0, 64'd0, 1'b1, 4'b0000, EX0, 1'b0, 32'h0);
    drive("cbzn_ex1", PC_JUMP, 1'b1, COND_EQ, 64'd3, 64'd0, 1'b0, 4'd0, EX1, 1'b0, 32'h0);
    check("cbzn.pc_const", pc, 64'h104);

    // Same-cycle hazard: status register is 0000, new flags must not be used
    drive("haz", PC_JUMP, 1'b1, COND_EQ, 64'd3, 64'd0, 1'b1, 4'b0100, EX0, 1'b0, 32'h0);
    check("haz.pc_const", pc, 64'h108);
    check("haz.status_const", {60'd0, status}, 64'h4);

    // BL then BR
    drive("setpc3", PC_IN, 1'b0, 4'd0, 64'd0, 64'h200, 1'b0, 4'd0, FETCH, 1'b0, 32'h0);
    check("bl.link_const", link_addr, 64'h204);
    drive("bl", PC_JUMP, 1'b0, COND_NE, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0, 4'd0, EX0,
          1'b0, 32'h0);
    check("bl.pc_const", pc, 64'h1F8);
    drive("br", PC_IN, 1'b0, 4'd0, 64'd0, 64'h307, 1'b0, 4'd0, FETCH, 1'b1, 32'hCAFE_F00D);
    check("br.pc_const", pc, 64'h304);

    // Wrap
    drive("setpc4", PC_IN, 1'b0, 4'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 4'd0, FETCH,
          1'b0, 32'h0);
    drive("wrap", PC_PLUS4, 1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 4'd0, EX1, 1'b0, 32'h0);
    check("wrap.pc_const", pc, 64'd0);

    // Exhaustive cond x status sweep through branch_taken (no clock edge inside)
    for (int s = 0; s < 16; s++) begin
      drive("ldst", PC_HOLD, 1'b0, 4'd0, 64'd0, 64'd0, 1'b1, 4'(s), FETCH, 1'b0, 32'h0);
      for (int c = 0; c < 16; c++) begin
        pc_fs = PC_JUMP; cond_en = 1'b1; cond = 4'(c); status_load = 1'b0;
        #1;
        check($sformatf("cond%0d_st%0d", c, s), {63'd0, branch_taken},
              {63'd0, ref_cond(4'(c), 4'(s))});
      end
      pc_fs = PC_HOLD;
      cond_en = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
